// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix stream sequencer (macro MATRIX_TRANSPOSE_EN adds column-major order).
package matrix_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SWAIT, STORE, DONE} ctrl_state_t;

  localparam logic CMD_LOAD  = 1'b0;
  localparam logic CMD_STORE = 1'b1;

  // Index width that stays at least one bit for single-row/column matrices.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_stream_ctrl_if.sv
// Command, element-stream and regfile-array bundle of the matrix sequencer.
// cmd_transpose exists only when MATRIX_TRANSPOSE_EN is defined.
interface matrix_stream_ctrl_if #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 4
);
  logic                              cmd_start;
  logic                              cmd_store;
`ifdef MATRIX_TRANSPOSE_EN
  logic                              cmd_transpose;
`endif
  logic                              busy;
  logic                              done;
  logic                              in_valid;
  logic [DW-1:0]                     in_data;
  logic                              in_ready;
  logic                              out_valid;
  logic [DW-1:0]                     out_data;
  logic                              out_last;
  logic                              out_ready;
  logic [0:RW-1][0:CW-1]             wren;
  logic [0:RW-1][0:CW-1][DW-1:0]     wr_data;
  logic [0:RW-1][0:CW-1][DW-1:0]     rd_data;

`ifdef MATRIX_TRANSPOSE_EN
  modport master (
    output cmd_transpose, cmd_start, cmd_store, in_valid, in_data, out_ready, rd_data,
    input  busy, done, in_ready, out_valid, out_data, out_last, wren, wr_data
  );
  modport slave (
    input  cmd_transpose, cmd_start, cmd_store, in_valid, in_data, out_ready, rd_data,
    output busy, done, in_ready, out_valid, out_data, out_last, wren, wr_data
  );
`else
  modport master (
    output cmd_start, cmd_store, in_valid, in_data, out_ready, rd_data,
    input  busy, done, in_ready, out_valid, out_data, out_last, wren, wr_data
  );
  modport slave (
    input  cmd_start, cmd_store, in_valid, in_data, out_ready, rd_data,
    output busy, done, in_ready, out_valid, out_data, out_last, wren, wr_data
  );
`endif

endinterface

// File: rtl/matrix_index_counter.sv
// Row/column element counter; walks row-major or column-major and wraps to (0,0) after the last element.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int RW  = 4,
  parameter int CW  = 4,
  parameter int RIW = idx_w(RW),
  parameter int CIW = idx_w(CW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  input  logic           col_major,
  output logic [RIW-1:0] row,
  output logic [CIW-1:0] col,
  output logic           is_last
);

  localparam logic [RIW-1:0] ROW_MAX = RIW'(RW - 1);
  localparam logic [CIW-1:0] COL_MAX = CIW'(CW - 1);

  logic [RIW-1:0] row_q;
  logic [CIW-1:0] col_q;
  logic           row_end;
  logic           col_end;

  assign row_end = (row_q == ROW_MAX);
  assign col_end = (col_q == COL_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (advance) begin
      if (col_major) begin
        if (row_end) begin
          row_q <= '0;
          col_q <= col_end ? '0 : col_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end else begin
        if (col_end) begin
          col_q <= '0;
          row_q <= row_end ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign is_last = row_end & col_end;

endmodule

// File: rtl/matrix_stream_ctrl.sv
// Moves a RW x CW matrix between a valid/ready element stream and the regfile arrays (MATRIX_TRANSPOSE_EN adds cmd_transpose).
// LOAD writes each accepted beat one cycle later; STORE emits first beat 2 cycles after command, stalls on !out_ready.
module matrix_stream_ctrl
  import matrix_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 4
) (
  input logic                 clk,
  input logic                 rst,
  matrix_stream_ctrl_if.slave bus
);

  localparam int RIW = idx_w(RW);
  localparam int CIW = idx_w(CW);

  ctrl_state_t                   state_q;
  ctrl_state_t                   state_d;
  logic [RIW-1:0]                row;
  logic [CIW-1:0]                col;
  logic                          is_last;
  logic                          col_major;
  logic                          cnt_clear;
  logic                          cnt_adv;
  logic                          in_ready;
  logic                          in_acc;
  logic                          out_load;
  logic                          remain_q;
  logic                          out_valid_q;
  logic                          out_last_q;
  logic [DW-1:0]                 out_data_q;
  logic [0:RW-1][0:CW-1]         wren_q;
  logic [0:RW-1][0:CW-1][DW-1:0] wr_data_q;

`ifdef MATRIX_TRANSPOSE_EN
  logic col_major_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_major_q <= 1'b0;
    end else if (state_q == IDLE && bus.cmd_start) begin
      col_major_q <= bus.cmd_transpose;
    end
  end

  assign col_major = col_major_q;
`else
  assign col_major = 1'b0;
`endif

  matrix_index_counter #(
    .RW  (RW),
    .CW  (CW),
    .RIW (RIW),
    .CIW (CIW)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .advance   (cnt_adv),
    .col_major (col_major),
    .row       (row),
    .col       (col),
    .is_last   (is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_load  = 1'b0;
    cnt_adv   = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (bus.cmd_start) begin
          state_d = (bus.cmd_store == CMD_STORE) ? SWAIT : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          cnt_adv = 1'b1;
          if (is_last) begin
            state_d = DONE;
          end
        end
      end
      // One idle cycle lets the last regfile write settle into rd_data.
      SWAIT: state_d = STORE;
      STORE: begin
        if ((!out_valid_q || bus.out_ready) && remain_q) begin
          out_load = 1'b1;
          cnt_adv  = 1'b1;
        end
        if (out_valid_q && bus.out_ready && out_last_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_acc = in_ready & bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wren_q    <= '0;
      wr_data_q <= '0;
    end else begin
      wren_q <= '0;
      if (in_acc) begin
        wren_q[row][col] <= 1'b1;
        wr_data_q        <= {(RW*CW){bus.in_data}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q <= 1'b0;
    end else if (state_q == SWAIT) begin
      remain_q <= 1'b1;
    end else if (out_load && is_last) begin
      remain_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.rd_data[row][col];
      out_last_q  <= is_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.wren      = wren_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Directed bench for matrix_stream_ctrl (4x4, DW=16) with a behavioural regfile; MATRIX_TRANSPOSE_EN adds the transpose case.
module tb_matrix_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [0:3][0:3][15:0] rf = '0;

  matrix_stream_ctrl_if #(.DW(16), .RW(4), .CW(4)) bus ();

  matrix_stream_ctrl #(.DW(16), .RW(4), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (bus.wren[r][c]) rf[r][c] <= bus.wr_data[r][c];
      end
    end
  end

  assign bus.rd_data = rf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] onehot(input int r, input int c);
    logic [0:3][0:3] m;
    m = '0;
    m[r][c] = 1'b1;
    return m;
  endfunction

  task automatic check_rf(input string tag, input int base, input bit tr);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s_rf%0d%0d", tag, r, c), rf[r][c], tr ? base + r + 4*c : base + 4*r + c);
      end
    end
  endtask

  task automatic do_load(input string tag, input int base, input bit gaps,
                         input bit repulse, input bit tr, input int nbeats);
    int   beat, k, pr, pc;
    bit   pend, acc;
    logic [15:0] pdat;
    @(posedge clk); #1;
    bus.cmd_start = 1'b1;
    bus.cmd_store = 1'b0;
`ifdef MATRIX_TRANSPOSE_EN
    bus.cmd_transpose = tr;
`endif
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    beat = 0; k = 0; pend = 1'b0; pr = 0; pc = 0; pdat = '0;
    while (beat < nbeats && k < 200) begin
      bus.in_valid  = gaps ? (k % 3 != 2) : 1'b1;
      bus.in_data   = 16'(base + beat);
      bus.cmd_start = repulse && (k == 6);
      bus.cmd_store = repulse && (k == 6);
      @(negedge clk);
      check({tag, "_wren"}, bus.wren, pend ? onehot(pr, pc) : 16'h0);
      if (pend) check({tag, "_wdata"}, bus.wr_data[3][3], pdat);
      check({tag, "_in_ready"}, bus.in_ready, 1'b1);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      pend = acc;
      if (acc) begin
        pr   = tr ? beat % 4 : beat / 4;
        pc   = tr ? beat / 4 : beat % 4;
        pdat = 16'(base + beat);
        beat++;
      end
      k++;
    end
    bus.in_valid  = 1'b0;
    bus.cmd_start = 1'b0;
    bus.cmd_store = 1'b0;
    check({tag, "_no_timeout"}, k < 200, 1'b1);
    if (nbeats == 16) begin
      @(negedge clk);
      check({tag, "_last_wren"}, bus.wren, onehot(pr, pc));
      check({tag, "_last_wdata"}, bus.wr_data[0][0], pdat);
      check({tag, "_done"}, bus.done, 1'b1);
      check({tag, "_done_busy"}, bus.busy, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_done_drop"}, bus.done, 1'b0);
      check({tag, "_idle_busy"}, bus.busy, 1'b0);
      check({tag, "_idle_wren"}, bus.wren, 16'h0);
    end
  endtask

  task automatic do_store(input string tag, input bit toggle, input int base, input bit tr_src);
    int   n, k, r, c;
    bit   stalled, rdy;
    logic [15:0] held;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.cmd_start = 1'b1;
    bus.cmd_store = 1'b1;
`ifdef MATRIX_TRANSPOSE_EN
    bus.cmd_transpose = 1'b0;
`endif
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    bus.cmd_store = 1'b0;
    @(negedge clk);
    check({tag, "_swait_vld"}, bus.out_valid, 1'b0);
    check({tag, "_swait_busy"}, bus.busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_pre_vld"}, bus.out_valid, 1'b0);
    @(posedge clk); #1;
    n = 0; k = 0; stalled = 1'b0; held = '0;
    while (n < 16 && k < 200) begin
      rdy = toggle ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      bus.out_ready = rdy;
      @(negedge clk);
      if (k == 0) check({tag, "_first_vld"}, bus.out_valid, 1'b1);
      if (stalled) check({tag, "_hold"}, bus.out_data, held);
      stalled = 1'b0;
      if (bus.out_valid && rdy) begin
        r = n / 4;
        c = n % 4;
        check($sformatf("%s_data%0d", tag, n), bus.out_data, tr_src ? base + r + 4*c : base + 4*r + c);
        check($sformatf("%s_last%0d", tag, n), bus.out_last, n == 15);
        n++;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held    = bus.out_data;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.out_ready = 1'b0;
    check({tag, "_no_timeout"}, k < 200, 1'b1);
    if (!toggle) check({tag, "_cycles"}, k, 16);
    @(negedge clk);
    check({tag, "_vld_drop"}, bus.out_valid, 1'b0);
    check({tag, "_done"}, bus.done, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_drop"}, bus.done, 1'b0);
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_store = 1'b0;
`ifdef MATRIX_TRANSPOSE_EN
    bus.cmd_transpose = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 16'h0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_wren", bus.wren, 16'h0);
    check("rst_wdata00", bus.wr_data[0][0], 16'h0);
    check("rst_wdata33", bus.wr_data[3][3], 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_load("load0", 0, 1'b0, 1'b0, 1'b0, 16);
    check_rf("load0", 0, 1'b0);
    do_store("st_full", 1'b0, 0, 1'b0);
    do_store("st_tog", 1'b1, 0, 1'b0);

    do_load("load_gap", 50, 1'b1, 1'b1, 1'b0, 16);
    check_rf("load_gap", 50, 1'b0);

    // Abort a load after five beats; beat 4 is still being written when reset is sampled.
    do_load("load_abort", 200, 1'b0, 1'b0, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pending_wren", bus.wren, onehot(1, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_wren", bus.wren, 16'h0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b0);
    check("abort_rf00", rf[0][0], 16'd200);
    check("abort_rf03", rf[0][3], 16'd203);
    check("abort_rf10", rf[1][0], 16'd204);
    check("abort_rf11", rf[1][1], 16'd55);

    do_load("load100", 100, 1'b0, 1'b0, 1'b0, 16);
    check_rf("load100", 100, 1'b0);
    do_store("st100", 1'b0, 100, 1'b0);

`ifdef MATRIX_TRANSPOSE_EN
    do_load("load_tr", 0, 1'b0, 1'b0, 1'b1, 16);
    check_rf("load_tr", 0, 1'b1);
    do_store("st_tr", 1'b0, 0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
